// File: rtl/imem_boot_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_pkg
// Purpose : Shared types and constants for the instruction-memory boot
//           loader: FSM state encoding, bytes-per-word constant and a small
//           helper that says which states are part of an active load.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package imem_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader is consuming the byte stream.
  function automatic logic is_loading(input state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Purpose : Packs accepted stream bytes big-endian into 32-bit words. The
//           first byte of a word lands in bits 31:24. When the last byte of
//           a word is accepted, the assembled word and a one-cycle valid
//           pulse appear on the following cycle.
// Ports   :
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_clear       restart the byte counter (new load)
//   i_byte_accept a data byte is transferred this cycle
//   i_byte        the data byte
//   o_last_byte   the next accepted byte completes a word (combinational)
//   o_word_valid  registered one-cycle pulse, o_word holds a complete word
//   o_word        registered assembled word
// ---------------------------------------------------------------------------
module word_assembler
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_accept,
  input  logic [7:0]  i_byte,
  output logic        o_last_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);

  logic [BYTE_CNT_W-1:0] r_cnt;
  // Only the first three bytes need holding; the fourth is taken directly.
  logic [23:0]           r_shift;
  logic                  r_word_valid;
  logic [31:0]           r_word;

  assign o_last_byte  = (r_cnt == LAST_IDX);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_byte_accept) begin
        r_shift <= {r_shift[15:0], i_byte};
        if (o_last_byte) begin
          r_word       <= {r_shift, i_byte};
          r_word_valid <= 1'b1;
          r_cnt        <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Purpose : Synthesizable instruction-memory preloader for the single-cycle
//           MIPS core. Receives LEN_HI, LEN_LO, N*4 data bytes and an XOR
//           checksum byte over a valid/ready handshake, writes the words to
//           imem from address 0 and releases the CPU reset only once the
//           checksum matches.
// Ports   :
//   clk, rst_n    clock, asynchronous active-low reset
//   start         pulse that begins/restarts a load (ignored while busy)
//   byte_valid    byte_data is valid
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle (decoded from state)
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     word address of the write
//   imem_wdata    instruction word
//   cpu_rst_n     active-low reset to the core, high only in RUN
//   busy          load in progress
//   done          image loaded and checksum verified
//   error         length out of range or checksum mismatch
//   words_loaded  words written in the current or last load
// ---------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0]   DEPTH_U = DEPTH;
  localparam logic [ADDR_W:0] WL_ONE = (ADDR_W+1)'(1);

  state_e            r_state;
  logic [7:0]        r_len_hi;
  logic [ADDR_W:0]   r_len;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_rst_n;

  logic              w_accept;
  logic              w_clear;
  logic              w_data_accept;
  logic              w_last_byte;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [15:0]       w_len_full;
  logic              w_last_word;

  assign byte_ready    = is_loading(r_state);
  assign w_accept      = byte_valid && byte_ready;
  assign w_data_accept = w_accept && (r_state == DATA);
  // start only has effect outside an active load
  assign w_clear       = start && !is_loading(r_state);
  assign w_len_full    = {r_len_hi, byte_data};
  assign w_last_word   = ((r_words_loaded + WL_ONE) == r_len);

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_byte_accept(w_data_accept),
    .i_byte       (byte_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Write strobe and data come straight from the assembler's registers;
  // imem_addr is latched on the same edge that raises the strobe.
  assign imem_we      = w_word_valid;
  assign imem_wdata   = w_word;
  assign imem_addr    = r_imem_addr;
  assign cpu_rst_n    = r_cpu_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_len_hi       <= '0;
      r_len          <= '0;
      r_chk          <= '0;
      r_imem_addr    <= '0;
      r_words_loaded <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_rst_n    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            r_state        <= LEN_HI;
            r_words_loaded <= '0;
            r_chk          <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_rst_n    <= 1'b0;
          end
        end
        LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= byte_data;
            r_state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_accept) begin
            if (w_len_full == 16'd0) begin
              r_len   <= '0;
              r_state <= CHK;
            end else if ({16'd0, w_len_full} > DEPTH_U) begin
              r_state <= ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_len   <= w_len_full[ADDR_W:0];
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_chk <= r_chk ^ byte_data;
            if (w_last_byte) begin
              // Word index of the write the assembler issues next cycle.
              r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
              r_words_loaded <= r_words_loaded + WL_ONE;
              if (w_last_word) begin
                r_state <= CHK;
              end
            end
          end
        end
        CHK: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (byte_data == r_chk) begin
              r_state     <= RUN;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Purpose : Directed self-checking bench for imem_boot_loader. Streams
//           hand-built images and compares flags and imem writes with
//           hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_total = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  logic [7:0]        stream[$];
  int                base;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      $display("write: addr=%0d data=%08h", imem_addr, imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (byte_ready !== 1'b1) check("handshake_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    $display("byte: %02h accepted (gap %0d)", b, gap);
  endtask

  task automatic send_stream(input int max_gap);
    foreach (stream[i]) send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk); #1;

    // ---- reset values ----
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_error",      {31'd0, error},      32'd0);
    check("rst_cpu_rst_n",  {31'd0, cpu_rst_n},  32'd0);
    check("rst_imem_we",    {31'd0, imem_we},    32'd0);
    check("rst_imem_addr",  32'(imem_addr),      32'd0);
    check("rst_imem_wdata", imem_wdata,          32'd0);
    check("rst_words",      32'(words_loaded),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // ---- good image, back-to-back ----
    base = log_addr.size();
    pulse_start();
    check("good_busy",  {31'd0, busy},       32'd1);
    check("good_ready", {31'd0, byte_ready}, 32'd1);
    stream = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02, 8'h1F};
    send_stream(0);
    check("good_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("good_a0",  32'(log_addr[base]),   32'd0);
    check("good_d0",  log_data[base],        32'h3C080001);
    check("good_a1",  32'(log_addr[base+1]), 32'd1);
    check("good_d1",  log_data[base+1],      32'h21090002);
    check("good_done",  {31'd0, done},       32'd1);
    check("good_cpu",   {31'd0, cpu_rst_n},  32'd1);
    check("good_error", {31'd0, error},      32'd0);
    check("good_busy_end", {31'd0, busy},    32'd0);
    check("good_words", 32'(words_loaded),   32'd2);

    // ---- same image with byte_valid gaps (restart from RUN) ----
    base = log_addr.size();
    pulse_start();
    check("gap_cpu_drop", {31'd0, cpu_rst_n}, 32'd0);
    check("gap_done_clr", {31'd0, done},      32'd0);
    send_byte(8'h00, 2);
    send_byte(8'h02, 1);
    repeat (3) @(posedge clk); #1;
    check("gap_ready_idle_valid", {31'd0, byte_ready}, 32'd1);
    stream = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02, 8'h1F};
    send_stream(5);
    check("gap_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("gap_d0",   log_data[base],         32'h3C080001);
    check("gap_a1",   32'(log_addr[base+1]),  32'd1);
    check("gap_d1",   log_data[base+1],       32'h21090002);
    check("gap_done", {31'd0, done},          32'd1);
    check("gap_cpu",  {31'd0, cpu_rst_n},     32'd1);
    check("gap_words", 32'(words_loaded),     32'd2);

    // ---- bad checksum ----
    base = log_addr.size();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02, 8'h3E};
    send_stream(0);
    check("bad_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("bad_error", {31'd0, error},     32'd1);
    check("bad_done",  {31'd0, done},      32'd0);
    check("bad_cpu",   {31'd0, cpu_rst_n}, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("bad_error_held", {31'd0, error}, 32'd1);

    // ---- N = 0x0401 > DEPTH ----
    base = log_addr.size();
    pulse_start();
    check("big_error_clr", {31'd0, error}, 32'd0);
    stream = '{8'h04, 8'h01};
    send_stream(0);
    check("big_error", {31'd0, error},      32'd1);
    check("big_ready", {31'd0, byte_ready}, 32'd0);
    check("big_busy",  {31'd0, busy},       32'd0);
    repeat (3) @(posedge clk); #1;
    check("big_nwrites", 32'(log_addr.size() - base), 32'd0);

    // ---- N = 0 ----
    base = log_addr.size();
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("zero_done",  {31'd0, done},      32'd1);
    check("zero_error", {31'd0, error},     32'd0);
    check("zero_cpu",   {31'd0, cpu_rst_n}, 32'd1);
    check("zero_words", 32'(words_loaded),  32'd0);
    check("zero_nwrites", 32'(log_addr.size() - base), 32'd0);

    // ---- reload one-word image from RUN ----
    base = log_addr.size();
    pulse_start();
    check("rl_cpu_drop", {31'd0, cpu_rst_n}, 32'd0);
    check("rl_done_clr", {31'd0, done},      32'd0);
    check("rl_busy",     {31'd0, busy},      32'd1);
    pulse_start();  // ignored while busy
    check("rl_start_ignored", {31'd0, byte_ready}, 32'd1);
    stream = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C};
    send_stream(0);
    check("rl_nwrites", 32'(log_addr.size() - base), 32'd1);
    check("rl_a0",   32'(log_addr[base]), 32'd0);
    check("rl_d0",   log_data[base],      32'h0000000C);
    check("rl_done", {31'd0, done},       32'd1);
    check("rl_words", 32'(words_loaded),  32'd1);

    // ---- reset mid-load after 6 data bytes ----
    base = log_addr.size();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(0);
    check("mid_nwrites", 32'(log_addr.size() - base), 32'd1);
    check("mid_d0", log_data[base], 32'h11223344);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_busy",  {31'd0, busy},       32'd0);
    check("mid_we",    {31'd0, imem_we},    32'd0);
    check("mid_words", 32'(words_loaded),   32'd0);
    check("mid_wdata", imem_wdata,          32'd0);
    check("mid_addr",  32'(imem_addr),      32'd0);
    check("mid_cpu",   {31'd0, cpu_rst_n},  32'd0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("mid_no_more_we", 32'(log_addr.size() - base), 32'd1);
    check("mid_idle_busy",  {31'd0, busy},       32'd0);
    check("mid_idle_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_idle_cpu",   {31'd0, cpu_rst_n},  32'd0);
    pulse_start();
    check("mid_restart_busy", {31'd0, busy}, 32'd1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
